// File: rtl/program_counter.sv
// Fetch-stage program counter: loads the next PC every cycle and exposes the
// sequential successor. Optional bounds flag is enabled with PC_BOUNDS_CHECK_EN.
module program_counter #(
    parameter int unsigned WIDTH        = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned STEP         = 1,
    parameter int unsigned IMEM_DEPTH   = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inPC,
    output logic [WIDTH-1:0] outPC,
    output logic [WIDTH-1:0] outPCPlus1
`ifdef PC_BOUNDS_CHECK_EN
    ,
    output logic             outPCOutOfRange
`endif
);

    localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VECTOR);
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

    logic [WIDTH-1:0] pc_r;

    // PC register: reset vector on rst, otherwise unconditionally take inPC
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= inPC;
        end
    end

    // Successor is combinational from the register; the carry-out is dropped
    assign outPC      = pc_r;
    assign outPCPlus1 = pc_r + STEP_W;

`ifdef PC_BOUNDS_CHECK_EN
    localparam logic [WIDTH-1:0] IMEM_LIMIT = WIDTH'(IMEM_DEPTH);

    logic outOfRange_r;

    // Flag tracks the value being loaded so it lines up with pc_r
    always_ff @(posedge clk) begin
        if (rst) begin
            outOfRange_r <= 1'b0;
        end else begin
            outOfRange_r <= (inPC >= IMEM_LIMIT);
        end
    end

    assign outPCOutOfRange = outOfRange_r;

    program_counter_checker uChecker (
        .clk             (clk),
        .rst             (rst),
        .outPCOutOfRange (outOfRange_r)
    );
`endif

endmodule

`ifdef PC_BOUNDS_CHECK_EN
// Flags any fetch address beyond instruction memory during normal operation.
module program_counter_checker (
    input logic clk,
    input logic rst,
    input logic outPCOutOfRange
);

    // A PC outside instruction memory while running is a control-flow bug upstream
    assert property (@(posedge clk) !(outPCOutOfRange && !rst))
        else $error("program_counter: PC outside instruction memory");

endmodule
`endif

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed cases from the block's
// behaviour plus randomized load/reset traffic against an arithmetic model.
module tb_program_counter;

    logic        clk;
    logic        rst;
    logic [31:0] inPC;
    logic [31:0] outPC;
    logic [31:0] outPCPlus1;
`ifdef PC_BOUNDS_CHECK_EN
    logic        outPCOutOfRange;
`endif

    int checkCount;
    int errorCount;

    // Reference state: what the PC should hold after the most recent edge
    longint unsigned modelPc;

    program_counter dut (
        .clk        (clk),
        .rst        (rst),
        .inPC       (inPC),
        .outPC      (outPC),
        .outPCPlus1 (outPCPlus1)
`ifdef PC_BOUNDS_CHECK_EN
        ,
        .outPCOutOfRange (outPCOutOfRange)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Apply inputs, take one rising edge, update the model, check #1 later
    task automatic stepAndCheck(input string tag, input logic rstVal, input logic [31:0] pcVal);
        rst  = rstVal;
        inPC = pcVal;
        @(posedge clk);
        modelPc = rstVal ? 64'd0 : {32'd0, pcVal};
        #1;
        checkValue({tag, ".pc"}, outPC, 32'(modelPc));
        checkValue({tag, ".plus1"}, outPCPlus1, 32'((modelPc + 64'd1) % 64'h1_0000_0000));
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        modelPc    = 64'd0;
        rst        = 1'b1;
        inPC       = 32'h0000_0000;
        @(negedge clk);

        // Reset ignores inPC
        stepAndCheck("reset_a", 1'b1, 32'h0000_000A);
        stepAndCheck("reset_b", 1'b1, 32'h0000_0064);

        // Normal loads, first one immediately after reset release
        stepAndCheck("load_64", 1'b0, 32'h0000_0064);
        stepAndCheck("load_20", 1'b0, 32'h0000_0020);

        // Reset raised between edges must not disturb the PC until the next edge
        #2;
        rst  = 1'b1;
        inPC = 32'h0000_0077;
        #2;
        checkValue("sync_rst_hold", outPC, 32'h0000_0020);
        stepAndCheck("sync_rst_edge", 1'b1, 32'h0000_0077);
        stepAndCheck("rst_release", 1'b0, 32'h0000_0040);

        // Sequential fetch by feeding the successor back
        stepAndCheck("seq_start", 1'b1, 32'h0000_0000);
        for (int i = 1; i <= 5; i++) begin
            #1;
            stepAndCheck("seq_fetch", 1'b0, outPCPlus1);
            checkValue("seq_count", outPC, 32'(i));
        end

        // Carry is discarded at the top of the address space
        stepAndCheck("wrap", 1'b0, 32'hFFFF_FFFF);

        // Randomized traffic against the model
        for (int i = 0; i < 200; i++) begin
            logic        rr;
            logic [31:0] pv;
            rr = ($urandom_range(0, 7) == 0);
            pv = $urandom;
            stepAndCheck("random", rr, pv);
        end

`ifdef PC_BOUNDS_CHECK_EN
        stepAndCheck("bound_1023", 1'b0, 32'd1023);
        checkValue("oor_1023", {31'd0, outPCOutOfRange}, 32'd0);
        stepAndCheck("bound_1024", 1'b0, 32'd1024);
        checkValue("oor_1024", {31'd0, outPCOutOfRange}, 32'd1);
        stepAndCheck("bound_rst", 1'b1, 32'd2000);
        checkValue("oor_rst", {31'd0, outPCOutOfRange}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
